// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB fade sequencer (gamma helper under RGB_GAMMA_EN).
// Latency: none; pure types, constants and combinational functions.
// Backpressure: not applicable.
package rgb_pkg;

    localparam int PWM_BITS_DEFAULT = 8;

    typedef logic [PWM_BITS_DEFAULT-1:0] duty_t;

    typedef struct packed {
        duty_t r;
        duty_t g;
        duty_t b;
    } rgb_t;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

    // One LSB toward the target; never wraps, holds when already there.
    function automatic duty_t step_toward(input duty_t duty, input duty_t target);
        duty_t res;
        res = duty;
        if (duty < target) begin
            res = duty + duty_t'(1);
        end else if (duty > target) begin
            res = duty - duty_t'(1);
        end
        return res;
    endfunction

`ifdef RGB_GAMMA_EN
    // Square-law brightness curve; a non-zero duty never collapses to fully off.
    function automatic duty_t gamma_map(input duty_t d);
        logic [2*PWM_BITS_DEFAULT-1:0] prod;
        duty_t                         g;
        prod = {{PWM_BITS_DEFAULT{1'b0}}, d} * {{PWM_BITS_DEFAULT{1'b0}}, d};
        g    = prod[2*PWM_BITS_DEFAULT-1:PWM_BITS_DEFAULT];
        if ((d != '0) && (g == '0)) begin
            g = duty_t'(1);
        end
        return g;
    endfunction
`endif

endpackage

// File: rtl/rgb_pwm_tick.sv
// Shared PWM timebase: prescaler producing tick, plus the period counter and period_end.
// Latency: tick/period_end are combinational from the registered counters.
// Backpressure: none; free-running after reset.
module rgb_pwm_tick #(
    parameter int CLK_DIV  = 1000,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                tick,
    output logic                period_end,
    output logic [PWM_BITS-1:0] pwm_cnt
);

    localparam int            PW        = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc;

    assign tick       = (presc == PRESC_MAX);
    assign period_end = tick && (pwm_cnt == '1);

    // Prescaler wraps on tick; the period counter advances once per tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end else begin
            presc   <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// RGB fade sequencer: accepts a colour command, ramps three duties to it, drives PWM pins (RGB_GAMMA_EN selects gamma).
// Latency: command accepted in one cycle; duties move only on period_end; fade_done one cycle after final update.
// Backpressure: cmd_ready is low for the whole fade; cmd_valid is ignored until the block is idle again.
module rgb_fade_sequencer
    import rgb_pkg::*;
#(
    parameter int CLK_DIV  = 1000,
    parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [PWM_BITS-1:0] cmd_r,
    input  logic [PWM_BITS-1:0] cmd_g,
    input  logic [PWM_BITS-1:0] cmd_b,
    input  logic [7:0]          cmd_step,
    output logic                busy,
    output logic                fade_done,
    output logic                red,
    output logic                green,
    output logic                blue
);

    logic                tick;
    logic                period_end;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] cnt_nxt;

    state_t     state, state_nxt;
    rgb_t       duty, duty_nxt;
    rgb_t       tgt, tgt_nxt;
    rgb_t       cmp, cmp_nxt, cmp_sel;
    logic [7:0] step_q, step_nxt;
    logic [7:0] step_cnt, step_cnt_nxt;
    logic       fade_done_nxt;
    logic       upd;

    rgb_pwm_tick #(
        .CLK_DIV  (CLK_DIV),
        .PWM_BITS (PWM_BITS)
    ) u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .period_end (period_end),
        .pwm_cnt    (pwm_cnt)
    );

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == FADE);
    assign cnt_nxt   = pwm_cnt + PWM_BITS'(1);

`ifdef RGB_GAMMA_EN
    assign cmp_nxt = '{r: gamma_map(duty_nxt.r), g: gamma_map(duty_nxt.g), b: gamma_map(duty_nxt.b)};
`else
    assign cmp_nxt = duty_nxt;
`endif

    // At period_end the new compare value applies to the first tick of the new period.
    assign cmp_sel = period_end ? cmp_nxt : cmp;

    // Next-state and datapath: accept in IDLE, step duties on period boundaries in FADE.
    always_comb begin
        state_nxt     = state;
        duty_nxt      = duty;
        tgt_nxt       = tgt;
        step_nxt      = step_q;
        step_cnt_nxt  = step_cnt;
        fade_done_nxt = 1'b0;
        upd           = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    tgt_nxt      = '{r: cmd_r, g: cmd_g, b: cmd_b};
                    step_nxt     = cmd_step;
                    step_cnt_nxt = '0;
                    state_nxt    = FADE;
                end
            end
            FADE: begin
                if (period_end) begin
                    if (step_q == 8'd0) begin
                        duty_nxt = tgt;
                        upd      = 1'b1;
                    end else if (step_cnt == step_q - 8'd1) begin
                        step_cnt_nxt = '0;
                        duty_nxt.r   = step_toward(duty.r, tgt.r);
                        duty_nxt.g   = step_toward(duty.g, tgt.g);
                        duty_nxt.b   = step_toward(duty.b, tgt.b);
                        upd          = 1'b1;
                    end else begin
                        step_cnt_nxt = step_cnt + 8'd1;
                    end
                    if (upd && (duty_nxt == tgt)) begin
                        state_nxt     = IDLE;
                        fade_done_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Fade state, latched command and duty/compare registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            duty      <= '0;
            tgt       <= '0;
            cmp       <= '0;
            step_q    <= '0;
            step_cnt  <= '0;
            fade_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            duty      <= duty_nxt;
            tgt       <= tgt_nxt;
            cmp       <= cmp_nxt;
            step_q    <= step_nxt;
            step_cnt  <= step_cnt_nxt;
            fade_done <= fade_done_nxt;
        end
    end

    // Registered PWM pins, re-evaluated once per tick against the upcoming count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            red   <= 1'b0;
            green <= 1'b0;
            blue  <= 1'b0;
        end else if (tick) begin
            red   <= (cnt_nxt < cmp_sel.r);
            green <= (cnt_nxt < cmp_sel.g);
            blue  <= (cnt_nxt < cmp_sel.b);
        end
    end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer: closed-form fade model checked every cycle, plus literal pulse-width checks.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_rgb_fade_sequencer;

    localparam int CLK_DIV = 4;
    localparam int PER     = CLK_DIV * 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_r = 8'd0;
    logic [7:0] cmd_g = 8'd0;
    logic [7:0] cmd_b = 8'd0;
    logic [7:0] cmd_step = 8'd0;
    logic       cmd_ready, busy, fade_done, red, green, blue;

    always #5 clk = ~clk;

    rgb_fade_sequencer #(.CLK_DIV(CLK_DIV), .PWM_BITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_r     (cmd_r),
        .cmd_g     (cmd_g),
        .cmd_b     (cmd_b),
        .cmd_step  (cmd_step),
        .busy      (busy),
        .fade_done (fade_done),
        .red       (red),
        .green     (green),
        .blue      (blue)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Brightness value the pin is compared against for a given duty.
    function automatic int mcmp(input int d);
`ifdef RGB_GAMMA_EN
        int g;
        g = (d * d) >> 8;
        if (d != 0 && g == 0) g = 1;
        return g;
`else
        return d;
`endif
    endfunction

    // Duty after p period boundaries of a fade from st to tg with s periods per LSB.
    function automatic int mdl_duty(input int st, input int tg, input int s, input int p);
        int mv;
        if (s == 0) return (p >= 1) ? tg : st;
        mv = p / s;
        if (st < tg) return (st + mv > tg) ? tg : st + mv;
        return (st - mv < tg) ? tg : st - mv;
    endfunction

    // Model state: t = clock edges since reset release.
    int t = 0;
    bit m_on = 1'b0;
    bit m_busy = 1'b0;
    int m_duty[3];
    int m_st[3];
    int m_tg[3];
    int m_s, m_p, m_pdone;
    bit e_out[3];
    bit e_done = 1'b0;

    always @(posedge clk) begin
        int dmax, d, cnt;
        if (!rst_n) begin
            t = 0; m_on = 1'b1; m_busy = 1'b0; e_done = 1'b0;
            for (int i = 0; i < 3; i++) begin m_duty[i] = 0; e_out[i] = 1'b0; end
        end else if (m_on) begin
            t++;
            e_done = 1'b0;
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_tg[0] = int'(cmd_r); m_tg[1] = int'(cmd_g); m_tg[2] = int'(cmd_b);
                    dmax = 0;
                    for (int i = 0; i < 3; i++) begin
                        m_st[i] = m_duty[i];
                        d = m_tg[i] - m_st[i];
                        if (d < 0) d = -d;
                        if (d > dmax) dmax = d;
                    end
                    m_s = int'(cmd_step);
                    m_p = 0;
                    m_pdone = (m_s == 0) ? 1 : m_s * ((dmax == 0) ? 1 : dmax);
                    m_busy = 1'b1;
                end
            end else if (t % PER == 0) begin
                m_p++;
                for (int i = 0; i < 3; i++) m_duty[i] = mdl_duty(m_st[i], m_tg[i], m_s, m_p);
                if (m_p == m_pdone) begin m_busy = 1'b0; e_done = 1'b1; end
            end
            if (t % CLK_DIV == 0) begin
                cnt = (t / CLK_DIV) % 256;
                for (int i = 0; i < 3; i++) e_out[i] = (cnt < mcmp(m_duty[i]));
            end
        end
    end

    // Per-cycle compare, high-time accumulation per PWM period, fade_done counting.
    int hi[3];
    int last_hi[3];
    int per_idx = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (m_on) begin
            chk("red",       int'(red),       int'(e_out[0]));
            chk("green",     int'(green),     int'(e_out[1]));
            chk("blue",      int'(blue),      int'(e_out[2]));
            chk("busy",      int'(busy),      int'(m_busy));
            chk("cmd_ready", int'(cmd_ready), int'(!m_busy));
            chk("fade_done", int'(fade_done), int'(e_done));
            if (fade_done) done_cnt++;
            if (t == 0) for (int i = 0; i < 3; i++) hi[i] = 0;
            hi[0] += int'(red); hi[1] += int'(green); hi[2] += int'(blue);
            if (t % PER == PER - 1) begin
                for (int i = 0; i < 3; i++) begin last_hi[i] = hi[i]; hi[i] = 0; end
                per_idx++;
            end
        end
    end

    task automatic wait_latches(input int k);
        int start, n;
        start = per_idx;
        n = 0;
        while (per_idx < start + k && n < (k + 2) * PER) begin
            @(negedge clk);
            n++;
        end
        chk("period_wait", int'(per_idx >= start + k), 1);
    endtask

    task automatic send(input int r, input int g, input int b, input int s);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_r = 8'(r); cmd_g = 8'(g); cmd_b = 8'(b); cmd_step = 8'(s);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (!fade_done && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", int'(fade_done), 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n, d0, s, tg[3];
        for (int i = 0; i < 3; i++) begin hi[i] = 0; last_hi[i] = 0; end

        // Reset: three cycles low, then three quiet periods.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_latches(1);
            chk("reset_red_hi",   last_hi[0], 0);
            chk("reset_green_hi", last_hi[1], 0);
            chk("reset_blue_hi",  last_hi[2], 0);
        end
        chk("reset_ready", int'(cmd_ready), 1);
        chk("reset_busy",  int'(busy), 0);
        chk("reset_no_done", done_cnt, 0);

        // Jump with step 0.
        d0 = done_cnt;
        send(128, 0, 255, 0);
        wait_done(2 * PER + 10, n);
        chk("jump_time", int'(n <= PER), 1);
        wait_latches(1);
        chk("jump_red_hi",   last_hi[0], 512);
        chk("jump_green_hi", last_hi[1], 0);
        chk("jump_blue_hi",  last_hi[2], PER - 4);
        chk("jump_done_once", done_cnt, d0 + 1);

        // Ramp from zero with step 2; cmd_valid held while busy must be ignored.
        pulse_reset();
        d0 = done_cnt;
        send(10, 5, 0, 2);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_r = 8'($urandom); cmd_g = 8'($urandom); cmd_b = 8'($urandom); cmd_step = 8'd0;
        repeat (300) @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(22 * PER, n);
        chk("ramp_time", int'(n > 19 * PER && n <= 20 * PER), 1);
        wait_latches(1);
        chk("ramp_red_hi",   last_hi[0], 40);
        chk("ramp_green_hi", last_hi[1], 20);
        chk("ramp_blue_hi",  last_hi[2], 0);
        chk("ramp_done_once", done_cnt, d0 + 1);

        // Ramp down/up by three LSB with step 1.
        send(200, 200, 200, 0);
        wait_done(2 * PER + 10, n);
        send(197, 203, 200, 1);
        wait_done(4 * PER, n);
        chk("updown_time", int'(n > 2 * PER && n <= 3 * PER), 1);
        wait_latches(1);
        chk("updown_red_hi",   last_hi[0], 197 * CLK_DIV);
        chk("updown_green_hi", last_hi[1], 203 * CLK_DIV);
        chk("updown_blue_hi",  last_hi[2], 200 * CLK_DIV);

        // Reset in the middle of a fade.
        pulse_reset();
        send(10, 5, 0, 2);
        repeat (7 * PER) @(negedge clk);
        d0 = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy",  int'(busy), 0);
        chk("midrst_ready", int'(cmd_ready), 1);
        chk("midrst_red",   int'(red), 0);
        chk("midrst_green", int'(green), 0);
        wait_latches(2);
        chk("midrst_red_hi",   last_hi[0], 0);
        chk("midrst_green_hi", last_hi[1], 0);
        chk("midrst_no_done",  done_cnt, d0);

        // Randomised commands against the model.
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(0, 50)) @(negedge clk);
            s = int'($urandom_range(0, 1));
            for (int i = 0; i < 3; i++) begin
                if (s == 0) tg[i] = int'($urandom_range(0, 255));
                else begin
                    tg[i] = m_duty[i] + int'($urandom_range(0, 6)) - 3;
                    if (tg[i] < 0) tg[i] = 0;
                    if (tg[i] > 255) tg[i] = 255;
                end
            end
            send(tg[0], tg[1], tg[2], s);
            wait_done(6 * PER, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
